// File: rtl/inv_shift_rows_stage_if.sv
// Stream bundle between the AddRoundKey side and the inverse S-box side of the
// AES decrypt pipe: one upstream (s_*) and one downstream (m_*) valid/ready channel.
interface inv_shift_rows_stage_if;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;

  // master: the environment around the stage (feeds s_*, consumes m_*)
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // slave: the stage itself
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/inv_shift_rows_stage.sv
// Registered InvShiftRows stage with a two-entry skid buffer (output reg + skid reg).
// Optional output-handshake counter on blk_cnt, enabled by defining INV_SHIFT_CNT_EN.
module inv_shift_rows_stage (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  inv_shift_rows_stage_if.slave        bus,
  output logic [15:0]                  blk_cnt
);

  // Handshake: a beat transfers on an edge where valid && ready are both high;
  // valid and its payload never change while valid && !ready.

  logic [127:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic [127:0] skid_data;
  logic         skid_valid;
  logic         skid_last;

  logic accept;
  logic drain;

  // byte n = r + 4c sits at bits [127-8n -: 8]; out(r,c) = in(r,(c-r) mod 4)
  function automatic logic [127:0] inv_shift(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c-r)&3)) -: 8];
      end
    end
    return o;
  endfunction

  assign accept      = bus.s_valid && !skid_valid;
  assign drain       = out_valid && bus.m_ready;

  assign bus.s_ready = !skid_valid;
  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_data;
  assign bus.m_last  = out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain || !out_valid) begin
      // Output slot frees up this edge: the older skid entry wins over new input,
      // and new input cannot arrive while the skid is full (s_ready is low).
      if (skid_valid) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data  <= inv_shift(bus.s_data);
        out_last  <= bus.s_last;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= inv_shift(bus.s_data);
      skid_last  <= bus.s_last;
      skid_valid <= 1'b1;
    end
  end

`ifdef INV_SHIFT_CNT_EN
  logic [15:0] cnt_q;

  // flush pre-empts the drain, so a flushed block is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain && !flush) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign blk_cnt = cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Bench for inv_shift_rows_stage: directed scenarios plus a randomized
// backpressure run against an expected queue; handles both INV_SHIFT_CNT_EN builds.
module tb_inv_shift_rows_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] blk_cnt;

  inv_shift_rows_stage_if sif ();

  inv_shift_rows_stage dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (sif),
    .blk_cnt (blk_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [128:0] exp_q[$];

  // Source byte index for each output byte, read off the hand-derived reference vector.
  localparam logic [127:0] SRC_MAP = 128'h000d0a0704010e0b0805020f0c090603;

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] map;
    logic [127:0] o;
    int s;
    map = SRC_MAP;
    o   = '0;
    for (int n = 0; n < 16; n++) begin
      s = int'(map[127-8*n -: 8]);
      o[127-8*n -: 8] = d[127-8*s -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] blk(input int k);
    logic [127:0] d;
    for (int n = 0; n < 16; n++) d[127-8*n -: 8] = 8'(k*7 + n*17 + 3);
    return d;
  endfunction

  function automatic logic [15:0] cnt_exp(input int c);
`ifdef INV_SHIFT_CNT_EN
    return 16'(c);
`else
    return 16'(c * 0);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    sif.m_ready = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", sif.m_valid); end
    total++; if (sif.m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", sif.m_last); end
    total++; if (sif.m_data !== 128'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", sif.m_data); end
    total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", sif.s_ready); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL reset_blk_cnt got=%h want=0", blk_cnt); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_vector();
    sif.s_valid = 1'b1;
    sif.s_data  = 128'h000102030405060708090a0b0c0d0e0f;
    sif.s_last  = 1'b1;
    sif.m_ready = 1'b1;
    step();
    sif.s_valid = 1'b0;
    total++; if (sif.m_valid !== 1'b1) begin bad++; $display("FAIL basic_m_valid got=%b want=1", sif.m_valid); end
    total++; if (sif.m_data !== 128'h000d0a0704010e0b0805020f0c090603) begin bad++; $display("FAIL basic_m_data got=%h want=000d0a0704010e0b0805020f0c090603", sif.m_data); end
    total++; if (sif.m_last !== 1'b1) begin bad++; $display("FAIL basic_m_last got=%b want=1", sif.m_last); end
    exp_cnt++;
    step();
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b want=0", sif.m_valid); end
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL basic_blk_cnt got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    sif.m_ready = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data = blk(1); sif.s_last = 1'b0;
    step();
    total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL bp_s_ready_c1 got=%b want=1", sif.s_ready); end
    sif.s_data = blk(2); sif.s_last = 1'b1;
    step();
    total++; if (sif.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready_c2 got=%b want=0", sif.s_ready); end
    sif.s_data = blk(3); sif.s_last = 1'b0;
    step();
    sif.s_valid = 1'b0;
    total++; if (sif.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready_c3 got=%b want=0", sif.s_ready); end
    total++; if (sif.m_valid !== 1'b1 || sif.m_data !== model(blk(1)) || sif.m_last !== 1'b0)
      begin bad++; $display("FAIL bp_hold_first got=%b/%h/%b want=1/%h/0", sif.m_valid, sif.m_data, sif.m_last, model(blk(1))); end
    sif.m_ready = 1'b1;
    step();
    exp_cnt++;
    total++; if (sif.m_valid !== 1'b1 || sif.m_data !== model(blk(2)) || sif.m_last !== 1'b1)
      begin bad++; $display("FAIL bp_second got=%b/%h/%b want=1/%h/1", sif.m_valid, sif.m_data, sif.m_last, model(blk(2))); end
    total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL bp_s_ready_back got=%b want=1", sif.s_ready); end
    step();
    exp_cnt++;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL bp_third_dropped got=%b want=0", sif.m_valid); end
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL bp_blk_cnt got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [128:0] e;
    sif.m_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = blk(100 + i);
      sif.s_last  = (i == 14);
      total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL b2b_s_ready i=%0d got=%b want=1", i, sif.s_ready); end
      exp_q.push_back({sif.s_last, model(sif.s_data)});
      step();
      if (i > 1) exp_cnt++;
      e = exp_q.pop_front();
      total++; if (sif.m_valid !== 1'b1 || {sif.m_last, sif.m_data} !== e)
        begin bad++; $display("FAIL b2b_out i=%0d got=%b/%b/%h want=1/%b/%h", i, sif.m_valid, sif.m_last, sif.m_data, e[128], e[127:0]); end
    end
    sif.s_valid = 1'b0;
    step();
    exp_cnt++;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", sif.m_valid); end
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL b2b_blk_cnt got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_random_backpressure();
    logic drn;
    logic acc;
    for (int i = 0; i < 300; i++) begin
      if (i < 296) begin
        sif.s_valid = 1'($urandom_range(0, 1));
        sif.m_ready = 1'($urandom_range(0, 1));
      end else begin
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
      end
      sif.s_data = blk(int'($urandom_range(0, 1000)));
      sif.s_last = ($urandom_range(0, 3) == 0);
      total++; if (sif.m_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL rnd_m_valid i=%0d got=%b want=%b", i, sif.m_valid, exp_q.size() > 0); end
      total++; if (sif.s_ready !== (exp_q.size() < 2)) begin bad++; $display("FAIL rnd_s_ready i=%0d got=%b want=%b", i, sif.s_ready, exp_q.size() < 2); end
      total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL rnd_blk_cnt i=%0d got=%h want=%h", i, blk_cnt, cnt_exp(exp_cnt)); end
      if (exp_q.size() > 0) begin
        total++; if ({sif.m_last, sif.m_data} !== exp_q[0])
          begin bad++; $display("FAIL rnd_data i=%0d got=%b/%h want=%b/%h", i, sif.m_last, sif.m_data, exp_q[0][128], exp_q[0][127:0]); end
      end
      drn = (exp_q.size() > 0) && sif.m_ready;
      acc = sif.s_valid && (exp_q.size() < 2);
      if (drn) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (acc) exp_q.push_back({sif.s_last, model(sif.s_data)});
      step();
    end
    total++; if (sif.m_valid !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%b want=0 left=%0d", sif.m_valid, exp_q.size()); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_flush();
    sif.m_ready = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data = blk(201); sif.s_last = 1'b1;
    step();
    sif.s_data = blk(202); sif.s_last = 1'b0;
    step();
    total++; if (sif.s_ready !== 1'b0 || sif.m_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got=%b/%b want=0/1", sif.s_ready, sif.m_valid); end
    sif.s_data = blk(203);
    flush = 1'b1;
    step();
    flush = 1'b0;
    sif.s_valid = 1'b0;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got=%b want=0", sif.m_valid); end
    total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL flush_s_ready got=%b want=1", sif.s_ready); end
    sif.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL flush_no_output i=%0d got=%b want=0", i, sif.m_valid); end
    end
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL flush_blk_cnt got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    sif.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = blk(300 + i);
      sif.s_last  = 1'b0;
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL async_rst_m_valid got=%b want=0", sif.m_valid); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL async_rst_blk_cnt got=%h want=0", blk_cnt); end
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    sif.s_data = blk(400);
    sif.s_last = 1'b1;
    step();
    sif.s_valid = 1'b0;
    total++; if (sif.m_valid !== 1'b1 || sif.m_data !== model(blk(400)) || sif.m_last !== 1'b1)
      begin bad++; $display("FAIL post_rst_first got=%b/%h/%b want=1/%h/1", sif.m_valid, sif.m_data, sif.m_last, model(blk(400))); end
    step();
    exp_cnt++;
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL post_rst_blk_cnt got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    int n;
`ifdef INV_SHIFT_CNT_EN
    n = 65537;
`else
    n = 40;
`endif
    do_reset();
    sif.m_ready = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      sif.s_data = blk(i);
      step();
    end
    sif.s_valid = 1'b0;
    step();
    exp_cnt = n % 65536;
    total++; if (blk_cnt !== cnt_exp(exp_cnt)) begin bad++; $display("FAIL cnt_wrap got=%h want=%h", blk_cnt, cnt_exp(exp_cnt)); end
    sif.m_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_vector();
    test_backpressure();
    test_back_to_back();
    test_random_backpressure();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stage.md
INV_SHIFT_ROWS_STAGE -- requirements
Module: inv_shift_rows_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port flush, input, 1, synchronous clear of all buffered blocks.
REQ-004 SHALL have port s_valid, input, 1, upstream block valid.
REQ-005 SHALL have port s_ready, output, 1, stage can accept a block.
REQ-006 SHALL have port s_data, input, 128, AES state, byte n = r+4c at bits [127-8n -: 8].
REQ-007 SHALL have port s_last, input, 1, final-round tag travelling with the block.
REQ-008 SHALL have port m_valid, output, 1, block available to the downstream inverse S-box stage.
REQ-009 SHALL have port m_ready, input, 1, downstream accepts the block.
REQ-010 SHALL have port m_data, output, 128, InvShiftRows result, same byte mapping.
REQ-011 SHALL have port m_last, output, 1, tag delivered with m_data.
REQ-012 SHALL have port blk_cnt, output, 16, count of output handshakes (see Configuration).

Function
REQ-013 SHALL compute out(r,c) = in(r,(c-r) mod 4); row 0 unshifted, rows 1/2/3 rotated right by 1/2/3 columns.
REQ-014 SHALL register the result: a block accepted on edge k appears on m_data at edge k (visible in cycle k+1), latency 1 cycle.
REQ-015 SHALL transfer input on s_valid&&s_ready and output on m_valid&&m_ready at the same edge.
REQ-016 SHALL hold two entries: output register plus one skid register.
REQ-017 SHALL drive s_ready from a register: s_ready=1 iff the skid register is empty.
REQ-018 SHALL, on input accept with output register empty or draining, load the output register directly.
REQ-019 SHALL, on input accept with output register full and not draining, load the skid register.
REQ-020 SHALL, when the output drains and the skid register is full, move the skid entry into the output register at that edge.
REQ-021 SHALL hold m_data, m_last and m_valid stable while m_valid&&!m_ready.
REQ-022 SHALL sustain 1 block/cycle when m_ready is continuously high.
REQ-023 SHALL preserve block order; s_last stays paired with its own block.
REQ-024 SHALL give flush priority over simultaneous accept/drain: both entries invalidated, m_valid=0, s_ready=1 next cycle, input dropped in the flush cycle.
REQ-025 SHALL ignore s_data/s_last when s_valid=0; m_data is don't-care when m_valid=0.

Reset
REQ-026 SHALL on rst: m_valid=0, m_last=0, m_data=0, skid register empty, s_ready=1, blk_cnt=0, independent of clk.
REQ-027 SHALL discard any in-flight blocks when rst asserts mid-operation; the first block after release exits after 1 cycle.

Configuration
REQ-028 SHALL use macro INV_SHIFT_CNT_EN to include the block counter.
REQ-029 SHALL, with INV_SHIFT_CNT_EN defined, increment blk_cnt by 1 per output handshake, wrapping FFFF->0000, cleared by rst but not by flush.
REQ-030 SHALL, without INV_SHIFT_CNT_EN, tie blk_cnt to 0 and include no counter flops.

Verification
REQ-031 SHALL cover: s_data=000102030405060708090a0b0c0d0e0f, m_ready=1 -> next cycle m_data=000d0a0704010e0b0805020f0c090603, m_valid=1.
REQ-032 SHALL cover: m_ready=0, three blocks offered back-to-back -> two accepted, s_ready=0 from cycle 2; m_ready=1 -> blocks emerge in order, s_ready returns to 1.
REQ-033 SHALL cover: continuous s_valid=m_ready=1 for 20 blocks with s_last on the 14th -> 20 outputs on consecutive cycles, m_last only on the 14th.
REQ-034 SHALL cover: two blocks buffered, flush=1 together with s_valid=1 -> next cycle m_valid=0, s_ready=1, no output from either block.
REQ-035 SHALL cover: rst asserted asynchronously mid-stream -> m_valid=0, blk_cnt=0 immediately, before the next clk edge.
REQ-036 SHALL cover: with INV_SHIFT_CNT_EN, preload via 65537 handshakes -> blk_cnt=0001; without the macro -> blk_cnt=0000 throughout.
